// File: rtl/irq_dispatch.sv
// irq_dispatch: SM83 interrupt controller (IE/IF/IME, priority, HALT/dispatch FSM, vector on bro)
// Ports:
//   CLK, nRES            clock, asynchronous active-low reset
//   irq_req              peripheral request levels, set IF bits
//   DL                   write data for IE/IF
//   wr_ie, wr_if         register write strobes
//   rd_ie, rd_if, rdata  register read selects and combinational read data
//   m1                   opcode-fetch (instruction boundary) strobe
//   ei, di, reti, halt   decoded instruction strobes
//   vec_sel              sequencer request to resolve the vector while dispatching
//   int_pending          any enabled request flagged
//   int_dispatch, halted FSM in DISP / HALT
//   bro                  vector bits [7:3], nonzero only in the vector-load cycle
//   ime                  master interrupt enable
module irq_dispatch #(
    parameter int NUM_IRQ = 5
) (
    input  logic               CLK,
    input  logic               nRES,
    input  logic [NUM_IRQ-1:0] irq_req,
    input  logic [7:0]         DL,
    input  logic               wr_ie,
    input  logic               wr_if,
    input  logic               rd_ie,
    input  logic               rd_if,
    output logic [7:0]         rdata,
    input  logic               m1,
    input  logic               ei,
    input  logic               di,
    input  logic               reti,
    input  logic               halt,
    input  logic               vec_sel,
    output logic               int_pending,
    output logic               int_dispatch,
    output logic               halted,
    output logic [4:0]         bro,
    output logic               ime
);
    typedef enum logic [1:0] {RUN, HALT, DISP, VEC} state_t;

    state_t     state_q, state_d;
    logic [7:0] ie_q, ie_d;
    logic [4:0] if_q, if_d;
    logic       ime_q, ime_d;
    logic       ei_pend_q, ei_pend_d;
    logic [4:0] bro_q, bro_d;
    logic [4:0] req_ext;
    logic [4:0] pend;
    logic [2:0] n;
    logic       resolve;

    always_comb begin
        req_ext = '0;
        for (int i = 0; i < NUM_IRQ; i++) req_ext[i] = irq_req[i];
    end

    assign pend        = ie_q[4:0] & if_q;
    assign int_pending = |pend;
    assign resolve     = (state_q == DISP) && vec_sel;

    // Lowest index wins: scan downward so the last hit is the smallest.
    always_comb begin
        n = '0;
        for (int i = 4; i >= 0; i--) if (pend[i]) n = 3'(i);
    end

    always_comb begin
        ie_d = wr_ie ? DL : ie_q;
        // Applied lowest priority first: write, then vector clear, then new requests.
        if_d = wr_if ? DL[4:0] : if_q;
        if (resolve && int_pending) if_d[n] = 1'b0;
        if_d = if_d | req_ext;
        ime_d     = ime_q;
        ei_pend_d = ei_pend_q;
        if (m1 && ei_pend_q) begin
            ime_d     = 1'b1;
            ei_pend_d = 1'b0;
        end
        if (ei) ei_pend_d = 1'b1;
        if (reti) ime_d = 1'b1;
        if (resolve) ime_d = 1'b0;
        if (di) begin
            ime_d     = 1'b0;
            ei_pend_d = 1'b0;
        end
    end

    // The dispatch check uses ime_q, so an EI takes effect one instruction late.
    always_comb begin
        state_d = state_q;
        bro_d   = '0;
        case (state_q)
            RUN:  state_d = (m1 && ime_q && int_pending) ? DISP :
                            (halt && !int_pending) ? HALT : RUN;
            HALT: state_d = !int_pending ? HALT : ime_q ? DISP : RUN;
            DISP: begin
                state_d = vec_sel ? VEC : DISP;
                bro_d   = (vec_sel && int_pending) ? {2'b01, n} : 5'd0;
            end
            VEC:  state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge CLK or negedge nRES) begin
        if (!nRES) begin
            state_q   <= RUN;
            ie_q      <= '0;
            if_q      <= '0;
            ime_q     <= 1'b0;
            ei_pend_q <= 1'b0;
            bro_q     <= '0;
        end else begin
            state_q   <= state_d;
            ie_q      <= ie_d;
            if_q      <= if_d;
            ime_q     <= ime_d;
            ei_pend_q <= ei_pend_d;
            bro_q     <= bro_d;
        end
    end

    assign rdata        = (rd_ie ? ie_q : 8'h00) | (rd_if ? {3'b111, if_q} : 8'h00);
    assign int_dispatch = (state_q == DISP);
    assign halted       = (state_q == HALT);
    assign bro          = bro_q;
    assign ime          = ime_q;
endmodule

// File: tb/tb_irq_dispatch.sv
// tb_irq_dispatch: directed and random stimulus for irq_dispatch against a behavioural model
module tb_irq_dispatch;
    localparam int M_RUN = 0, M_HALT = 1, M_DISP = 2, M_VEC = 3;

    logic       CLK = 1'b0;
    logic       nRES;
    logic [4:0] irq_req;
    logic [7:0] DL;
    logic       wr_ie, wr_if, rd_ie, rd_if, m1, ei, di, reti, halt, vec_sel;
    logic [7:0] rdata;
    logic       int_pending, int_dispatch, halted, ime;
    logic [4:0] bro;

    int ncmp = 0;
    int nerr = 0;

    logic [7:0] m_ie;
    logic [4:0] m_if;
    logic [4:0] m_bro;
    bit         m_ime, m_ep;
    int         m_mode;

    irq_dispatch #(.NUM_IRQ(5)) dut (
        .CLK(CLK), .nRES(nRES), .irq_req(irq_req), .DL(DL),
        .wr_ie(wr_ie), .wr_if(wr_if), .rd_ie(rd_ie), .rd_if(rd_if), .rdata(rdata),
        .m1(m1), .ei(ei), .di(di), .reti(reti), .halt(halt), .vec_sel(vec_sel),
        .int_pending(int_pending), .int_dispatch(int_dispatch), .halted(halted),
        .bro(bro), .ime(ime)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        ncmp++;
        assert (got === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_ie = 8'h00; m_if = 5'h00; m_bro = 5'h00; m_ime = 0; m_ep = 0; m_mode = M_RUN;
    endtask

    task automatic clr();
        irq_req = 0; DL = 0; wr_ie = 0; wr_if = 0; rd_ie = 0; rd_if = 0;
        m1 = 0; ei = 0; di = 0; reti = 0; halt = 0; vec_sel = 0;
    endtask

    task automatic check_all();
        logic [4:0] p;
        p = m_ie[4:0] & m_if;
        chk("int_pending", 8'(int_pending), 8'(|p));
        chk("int_dispatch", 8'(int_dispatch), 8'(m_mode == M_DISP));
        chk("halted", 8'(halted), 8'(m_mode == M_HALT));
        chk("bro", 8'(bro), 8'(m_bro));
        chk("ime", 8'(ime), 8'(m_ime));
        chk("rdata", rdata, (rd_ie ? m_ie : 8'h00) | (rd_if ? {3'b111, m_if} : 8'h00));
    endtask

    // One clock: the model applies the interrupt rules to the inputs seen at the edge.
    task automatic tick();
        logic [4:0] p, nif, nbro;
        int n, nmode;
        bit res, nime, nep;
        @(posedge CLK);
        #1;
        if (!nRES) model_reset();
        else begin
            p = m_ie[4:0] & m_if;
            n = -1;
            for (int i = 0; i < 5; i++) if (p[i] && n < 0) n = i;
            res = (m_mode == M_DISP) && vec_sel;
            nif = wr_if ? DL[4:0] : m_if;
            if (res && n >= 0) nif[n] = 1'b0;
            nif = nif | irq_req;
            nime = di ? 1'b0 : res ? 1'b0 : (reti || (m1 && m_ep)) ? 1'b1 : m_ime;
            nep  = di ? 1'b0 : ei ? 1'b1 : (m1 && m_ep) ? 1'b0 : m_ep;
            nbro = (res && n >= 0) ? 5'((8'h40 + 8 * n) >> 3) : 5'd0;
            nmode = m_mode;
            if (m_mode == M_RUN) begin
                if (m1 && m_ime && p != 0) nmode = M_DISP;
                else if (halt && p == 0) nmode = M_HALT;
            end else if (m_mode == M_HALT) begin
                if (p != 0) nmode = m_ime ? M_DISP : M_RUN;
            end else if (m_mode == M_DISP) begin
                if (vec_sel) nmode = M_VEC;
            end else nmode = M_RUN;
            if (wr_ie) m_ie = DL;
            m_if = nif; m_ime = nime; m_ep = nep; m_bro = nbro; m_mode = nmode;
        end
        check_all();
        clr();
    endtask

    task automatic rd(input bit s_ie, input bit s_if, input logic [7:0] exp, input string tag);
        rd_ie = s_ie; rd_if = s_if;
        #1;
        chk(tag, rdata, exp);
        rd_ie = 0; rd_if = 0;
    endtask

    initial begin
        clr();
        nRES = 1'b1;
        #2 nRES = 1'b0;
        #1;
        model_reset();
        check_all();
        rd(0, 1, 8'hE0, "reset_if");
        rd(1, 0, 8'h00, "reset_ie");
        tick();
        nRES = 1'b1;

        wr_ie = 1; DL = 8'h05; tick();
        wr_if = 1; DL = 8'h05; tick();
        reti = 1; tick();
        chk("reti_ime", 8'(ime), 8'h01);
        m1 = 1; tick();
        chk("disp_enter", 8'(int_dispatch), 8'h01);
        vec_sel = 1; tick();
        chk("vec40_bro", 8'(bro), 8'h08);
        chk("vec40_ime", 8'(ime), 8'h00);
        rd(0, 1, 8'hE4, "vec40_if");
        tick();
        chk("vec_end_bro", 8'(bro), 8'h00);

        wr_if = 1; DL = 8'h01; tick();
        ei = 1; tick();
        m1 = 1; tick();
        chk("ei_delay_nodisp", 8'(int_dispatch), 8'h00);
        chk("ei_delay_ime", 8'(ime), 8'h01);
        m1 = 1; tick();
        chk("ei_next_disp", 8'(int_dispatch), 8'h01);
        vec_sel = 1; tick();
        tick();

        wr_if = 1; DL = 8'h00; tick();
        halt = 1; tick();
        chk("halt_enter", 8'(halted), 8'h01);
        irq_req = 5'b00100; tick();
        chk("halt_pend", 8'(int_pending), 8'h01);
        chk("halt_still", 8'(halted), 8'h01);
        tick();
        chk("halt_wake", 8'(halted), 8'h00);
        chk("halt_nodisp", 8'(int_dispatch), 8'h00);

        reti = 1; tick();
        m1 = 1; tick();
        wr_ie = 1; DL = 8'h00; tick();
        chk("disp_wait", 8'(int_dispatch), 8'h01);
        vec_sel = 1; tick();
        chk("empty_bro", 8'(bro), 8'h00);
        chk("empty_ime", 8'(ime), 8'h00);
        rd(0, 1, 8'hE4, "empty_if");
        tick();

        wr_ie = 1; DL = 8'h02; tick();
        irq_req = 5'b00010; wr_if = 1; DL = 8'h00; tick();
        rd(0, 1, 8'hE2, "req_beats_write");
        rd(1, 1, 8'hE2, "read_both");
        reti = 1; tick();
        m1 = 1; tick();
        vec_sel = 1; tick();
        chk("vec48_bro", 8'(bro), 8'h09);
        nRES = 1'b0;
        #1;
        model_reset();
        chk("async_bro", 8'(bro), 8'h00);
        chk("async_disp", 8'(int_dispatch), 8'h00);
        check_all();
        tick();
        nRES = 1'b1;

        for (int c = 0; c < 600; c++) begin
            irq_req = ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'd0;
            DL      = 8'($urandom);
            wr_ie   = ($urandom_range(0, 11) == 0);
            wr_if   = ($urandom_range(0, 11) == 0);
            rd_ie   = ($urandom_range(0, 2) == 0);
            rd_if   = ($urandom_range(0, 2) == 0);
            m1      = ($urandom_range(0, 2) == 0);
            ei      = ($urandom_range(0, 9) == 0);
            di      = ($urandom_range(0, 19) == 0);
            reti    = ($urandom_range(0, 9) == 0);
            halt    = ($urandom_range(0, 14) == 0);
            vec_sel = ($urandom_range(0, 3) == 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule

// File: doc/irq_dispatch.md
# irq_dispatch

Interrupt controller for the SM83 core. Holds the IE and IF registers and the IME flag, and resolves interrupt priority. Runs the HALT/dispatch state machine that tells the sequencer when to replace an opcode fetch with an interrupt call. Produces the interrupt vector on `bro[7:3]`, which the PC block ORs into its PCL input during the vector-load cycle.

## Interface
Parameters:
- `NUM_IRQ`, default 5: number of interrupt sources. The priority encoder and vector width rely on a value of 5 or less.

Ports:
- `CLK` in 1: core clock. All state updates on the rising edge.
- `nRES` in 1: asynchronous, active-low reset.
- `irq_req` in NUM_IRQ: peripheral request levels. A high level in a cycle sets the matching IF bit.
- `DL` in 8: internal data bus, used as write data.
- `wr_ie`, `wr_if` in 1: write strobes for IE (FFFF) and IF (FF0F).
- `rd_ie`, `rd_if` in 1: read selects.
- `rdata` out 8: read data. 0 when no read select is active.
- `m1` in 1: instruction-boundary strobe (opcode-fetch cycle).
- `ei`, `di`, `reti`, `halt` in 1: decoded instruction strobes, one cycle each.
- `vec_sel` in 1: sequencer strobe that asks for vector resolution during dispatch.
- `int_pending` out 1: OR of (IE[4:0] & IF[4:0]).
- `int_dispatch` out 1: high while in state DISP.
- `halted` out 1: high while in state HALT.
- `bro` out 5: vector bits [7:3]. Nonzero only in state VEC.
- `ime` out 1: current IME flag.

## Operation
Registers:
- IE is 8 bits. Only bits [4:0] take part in priority.
- IF is 5 bits. It reads back as {3'b111, IF}.
- IME is 1 bit. `ei_pend` is 1 bit.

IF update priority, per bit, highest first:
- `irq_req` set
- clear on vector resolution
- `wr_if` write from DL[4:0]

A request arriving in the same cycle as a clear or a 0-write therefore leaves the bit set.

IME control:
- `di`: clears IME and `ei_pend` at the next edge.
- `reti`: sets IME at the next edge.
- `ei`: sets `ei_pend`. At the next `m1` with `ei_pend`=1, IME←1 and `ei_pend`←0.
- The interrupt check at that same `m1` uses the old IME. This gives EI its one-instruction delay.
- If `di` and `ei` arrive together, `di` wins.

State machine (states RUN, HALT, DISP, VEC):
- RUN → DISP: `m1` && IME && `int_pending`.
- RUN → HALT: `halt` && !`int_pending`.
- RUN, `halt` with `int_pending`=1: stays in RUN. HALT is not entered.
- HALT → RUN: `int_pending` && !IME. Execution resumes and the request is not serviced.
- HALT → DISP: `int_pending` && IME.
- DISP → VEC: `vec_sel`. The vector is resolved at this edge:
  - n = lowest set index of IE[4:0]&IF[4:0].
  - `bro` register ← {1'b0, 1'b1, n[2:0]}, giving vectors 0x40/48/50/58/60.
  - IF[n]←0 and IME←0.
- If nothing is pending at `vec_sel` (IE or IF rewritten during the push), `bro` ← 0. PC then loads 0x0000, IF is unchanged, and IME←0.
- VEC → RUN: unconditional after one cycle. The `bro` register returns to 0.
- DISP with no `vec_sel`: waits indefinitely.

## Timing
- Reset values: IE=0x00, IF=0, IME=0, `ei_pend`=0, state RUN. All outputs are 0: `bro`=0, `int_dispatch`=0, `halted`=0, `int_pending`=0, `ime`=0, and `rdata`=0.
- `irq_req` high at edge t: IF bit visible after t. `int_pending` is combinational and high in the cycle after t.
- `m1` at edge t meeting the dispatch condition: `int_dispatch`=1 from t until the edge that samples `vec_sel`.
- `vec_sel` at edge t: `bro` is valid for exactly the cycle t..t+1. IF and IME are cleared at t. `int_dispatch` is 0 from t.
- HALT wake: `halted` drops one cycle after `int_pending` rises.
- `rdata` is combinational from registers. If both read selects are active, the result is IE | {3'b111, IF}.
- `nRES` low at any point, including DISP or VEC: immediate return to reset values, and `bro` drops asynchronously.

## Test plan
- Reset, then read IF → `rdata`=0xE0. Read IE → `rdata`=0x00. All outputs are 0.
- IE=0x05, IF=0x05, IME=1, `m1` → `int_dispatch`=1. `vec_sel` → `bro`=5'b01000 (0x40) for one cycle, IF=0x04, IME=0.
- `ei` then `m1`: no dispatch at that `m1` while 0x01 is pending. At the next `m1`, DISP is entered.
- `halt` with IME=0 and nothing pending → `halted`=1. `irq_req[2]` pulse → `halted`=0 one cycle after `int_pending`, and no dispatch occurs.
- In DISP, write IE=0x00, then `vec_sel` → `bro`=0, IF unchanged, IME=0.
- `irq_req[1]` in the same cycle as `wr_if` DL=0x00 → IF=0x02. Then assert `nRES` low while in VEC → `bro`=0 immediately and state is RUN.
